// File: rtl/risc_instr_feeder.sv
// Instruction feeder for the 8-bit RISC core: holds a host-loaded program,
// issues one word per ISSUE_GAP+1 cycles and captures the core's result.
module risc_instr_feeder #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int ISSUE_GAP = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [13:0]   load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          abort,
  output logic [13:0]   instr,
  output logic          instr_valid,
  input  logic [7:0]    dataout_in,
  input  logic          carry_in,
  input  logic          sign_in,
  input  logic          zero_in,
  output logic          res_valid,
  output logic [7:0]    res_data,
  output logic [2:0]    res_flags,
  output logic [AW-1:0] res_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    FIN     = 3'd4
  } state_t;

  localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE  = (AW+1)'(1);
  // WAIT lasts ISSUE_GAP-1 cycles so res_valid lands ISSUE_GAP after instr_valid
  localparam logic [3:0]  GAP_LOAD = 4'(ISSUE_GAP - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [3:0]    gap_q, gap_d;
  logic [13:0]   instr_q, instr_d;
  logic          instr_valid_q, instr_valid_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_data_q, res_data_d;
  logic [2:0]    res_flags_q, res_flags_d;
  logic [AW-1:0] res_idx_q, res_idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [13:0]   mem_q [DEPTH];
  logic [AW:0]   len_clamped;
  logic          last_word;

  assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign last_word   = ({1'b0, pc_q} == (len_q - LEN_ONE));

  // Program memory is deliberately not reset so a program survives rst_n
  always_ff @(posedge clk) begin
    if (load_en && (state_q == IDLE)) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    len_d         = len_q;
    gap_d         = gap_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    res_valid_d   = 1'b0;
    res_data_d    = res_data_q;
    res_flags_d   = res_flags_q;
    res_idx_d     = res_idx_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            if (len_clamped != '0) begin
              len_d   = len_clamped;
              pc_d    = '0;
              busy_d  = 1'b1;
              state_d = ISSUE;
            end else begin
              state_d = FIN;
            end
          end
        end
        ISSUE: begin
          instr_d       = mem_q[pc_q];
          instr_valid_d = 1'b1;
          gap_d         = GAP_LOAD;
          state_d       = WAIT;
        end
        WAIT: begin
          gap_d = (gap_q == '0) ? '0 : gap_q - 4'd1;
          if (gap_q <= 4'd1) begin
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          res_data_d  = dataout_in;
          res_flags_d = {carry_in, sign_in, zero_in};
          res_idx_d   = pc_q;
          res_valid_d = 1'b1;
          if (last_word) begin
            state_d = FIN;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = ISSUE;
          end
        end
        FIN: begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      len_q         <= '0;
      gap_q         <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_flags_q   <= '0;
      res_idx_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      len_q         <= len_d;
      gap_q         <= gap_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_flags_q   <= res_flags_d;
      res_idx_q     <= res_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_flags   = res_flags_q;
  assign res_idx     = res_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_risc_instr_feeder.sv
// Scoreboard bench for risc_instr_feeder: a tiny core model answers each
// issued word, and a negedge monitor checks words, results and timing.
module tb_risc_instr_feeder;

  localparam int G = 3;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [13:0] load_data;
  logic [4:0]  prog_len;
  logic        start;
  logic        abort;
  logic [13:0] instr;
  logic        instr_valid;
  logic [7:0]  dataout_in;
  logic        carry_in;
  logic        sign_in;
  logic        zero_in;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [2:0]  res_flags;
  logic [3:0]  res_idx;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int startCyc = 0;
  int lastIssueCyc = 0;
  int lastResCyc   = 0;
  int runWords  = 0;
  int runIssues = 0;
  bit expectDone = 0;
  bit doneSeen   = 0;

  logic [13:0] tbMem [16];
  logic [13:0] expInstrQ [$];
  logic [14:0] expResQ [$];

  risc_instr_feeder #(.DEPTH(16), .AW(4), .ISSUE_GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start), .abort(abort),
    .instr(instr), .instr_valid(instr_valid), .dataout_in(dataout_in),
    .carry_in(carry_in), .sign_in(sign_in), .zero_in(zero_in),
    .res_valid(res_valid), .res_data(res_data), .res_flags(res_flags),
    .res_idx(res_idx), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Core model: result is a function of the word just issued
  always @(posedge clk) begin
    if (instr_valid) begin
      dataout_in <= instr[7:0] ^ 8'hA0;
      carry_in   <= instr[11];
      sign_in    <= instr[12];
      zero_in    <= (instr[7:0] == 8'hA0);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_valid) begin
        if (expInstrQ.size() == 0) begin
          checkOutput("instr_extra", 32'(instr_valid), 32'd0);
        end else begin
          checkOutput("instr", 32'(instr), 32'(expInstrQ.pop_front()));
          if (runIssues == 0) checkOutput("first_issue_lat", 32'(cycle - startCyc), 32'd2);
          else                checkOutput("issue_gap", 32'(cycle - lastResCyc), 32'd1);
          runIssues++;
          lastIssueCyc = cycle;
        end
      end
      if (res_valid) begin
        if (expResQ.size() == 0) begin
          checkOutput("res_extra", 32'(res_valid), 32'd0);
        end else begin
          checkOutput("res_idx_flags_data", 32'({res_idx, res_flags, res_data}), 32'(expResQ.pop_front()));
          checkOutput("res_latency", 32'(cycle - lastIssueCyc), 32'(G));
          lastResCyc = cycle;
        end
      end
      if (done) begin
        if (!expectDone) begin
          checkOutput("done_extra", 32'(done), 32'd0);
        end else begin
          checkOutput("done_busy", 32'(busy), 32'd0);
          checkOutput("run_cycles", 32'(cycle - startCyc), 32'(runWords * (G + 1) + 2));
          doneSeen   = 1;
          expectDone = 0;
        end
      end
    end
  end

  task automatic loadWord(input int addr, input logic [13:0] data);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = 4'(addr); load_data = data;
    tbMem[addr] = data;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic applyStimulus(input int len);
    int n;
    logic [13:0] w;
    logic [7:0] d;
    n = (len > 16) ? 16 : len;
    for (int i = 0; i < n; i++) begin
      w = tbMem[i];
      d = w[7:0] ^ 8'hA0;
      expInstrQ.push_back(w);
      expResQ.push_back({4'(i), w[11], w[12], (d == 8'h00), d});
    end
    runWords = n; runIssues = 0; doneSeen = 0; expectDone = 1;
    @(posedge clk); #1;
    prog_len = 5'(len); start = 1'b1; startCyc = cycle;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone();
    for (int k = 0; k < 300 && !doneSeen; k++) @(posedge clk);
    #1;
    checkOutput("done_seen", 32'(doneSeen), 32'd1);
    checkOutput("instr_q_left", 32'(expInstrQ.size()), 32'd0);
    checkOutput("res_q_left", 32'(expResQ.size()), 32'd0);
    expInstrQ.delete(); expResQ.delete(); expectDone = 0;
  endtask

  task automatic waitIssues(input int n);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (runIssues >= n) break;
    end
    checkOutput("issue_reached", 32'(runIssues >= n), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    prog_len = '0; start = 1'b0; abort = 1'b0;
    dataout_in = '0; carry_in = 1'b0; sign_in = 1'b0; zero_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 32'({instr, instr_valid, res_valid, res_data, res_flags, res_idx, busy, done}), 32'd0);
    rst_n = 1'b1;

    loadWord(0, 14'h0E05);
    loadWord(1, 14'h0F09);
    loadWord(2, 14'h1476);
    applyStimulus(3);
    waitDone();

    applyStimulus(0);
    checkOutput("len0_busy", 32'(busy), 32'd0);
    waitDone();

    applyStimulus(3);
    load_en = 1'b1; load_addr = 4'd1; load_data = 14'h3FFF;
    repeat (3) @(posedge clk);
    #1 load_en = 1'b0;
    waitDone();
    applyStimulus(3);
    waitDone();

    for (int i = 3; i < 16; i++) loadWord(i, 14'((i * 14'h0531) ^ (i << 10)));
    loadWord(7, 14'h08A0);
    applyStimulus(20);
    waitDone();

    applyStimulus(3);
    waitIssues(2);
    #1;
    abort = 1'b1; expectDone = 0;
    checkOutput("abort_res_left", 32'(expResQ.size()), 32'd2);
    expInstrQ.delete(); expResQ.delete();
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    repeat (15) @(posedge clk);
    applyStimulus(3);
    waitDone();

    @(posedge clk); #1;
    prog_len = 5'd3; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checkOutput("abort_start_busy", 32'(busy), 32'd0);
    repeat (8) @(posedge clk);

    applyStimulus(3);
    waitIssues(1);
    #2;
    rst_n = 1'b0; expectDone = 0;
    #1;
    checkOutput("async_reset_outputs", 32'({instr, instr_valid, res_valid, res_data, res_flags, res_idx, busy, done}), 32'd0);
    expInstrQ.delete(); expResQ.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(3);
    waitDone();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/risc_instr_feeder.md
Name: risc_instr_feeder

Overview:
Initiator side of the 8-bit RISC core's instruction interface. It holds a small program buffer, loaded by a host, and streams 14-bit instructions to the core at the core's fetch/decode/execute cadence. After each instruction completes, it samples the core's dataout and flags into a result register and pulses a valid strobe to the host. It sits between the testbench/host loader and the core, replacing the hand-timed instruction drive.

Parameters:
DEPTH, 16, number of program words held (power of two).
AW, 4, program address width (log2 DEPTH).
ISSUE_GAP, 3, cycles from instruction issue to result sample (core ideal/decode/exec cadence); legal range 2..15.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
load_en  input  1  write program word (ignored while busy)
load_addr  input  AW  program word address
load_data  input  14  program word {type[13:12], op[11:8], operand[7:0]}
prog_len  input  AW+1  number of words to run, 0..DEPTH (values >DEPTH clamp to DEPTH)
start  input  1  begin run from address 0 (sampled only in IDLE)
abort  input  1  synchronous cancel of a run
instr  output  14  instruction to core
instr_valid  output  1  one-cycle pulse: instr holds a new word
dataout_in  input  8  core dataout
carry_in, sign_in, zero_in  input  1 each  core flags
res_valid  output  1  one-cycle pulse: res_data/res_flags updated
res_data  output  8  sampled core dataout
res_flags  output  3  sampled {carry,sign,zero}
res_idx  output  AW  program address of the instruction whose result is presented
busy  output  1  run in progress
done  output  1  one-cycle pulse at run completion

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; instr=0, instr_valid=0, res_valid=0, res_data=0, res_flags=0, res_idx=0, busy=0, done=0, pc=0, gap counter=0. Program memory is not reset; its contents are retained across reset.
- Program memory: synchronous write on clk when load_en=1 and state is IDLE. Writes while busy are dropped. Addresses wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, FIN.
- IDLE: start=1 with clamped prog_len>0 latches len, sets pc=0 and busy=1, then moves to ISSUE. start=1 with prog_len=0 moves to FIN; done pulses with no issue.
- ISSUE (1 cycle): registers instr=mem[pc] and instr_valid=1 (visible the next cycle, t), loads the gap counter, then moves to WAIT.
- WAIT: counts down. Moves to CAPTURE so that res_valid is high exactly at cycle t+ISSUE_GAP.
- CAPTURE: samples res_data=dataout_in, res_flags={carry_in,sign_in,zero_in}, res_idx=pc, and pulses res_valid.
  - If pc==len-1, moves to FIN.
  - Otherwise pc=pc+1 and moves to ISSUE, so the next instr_valid falls at t+ISSUE_GAP+1.
- FIN: busy=0 and done=1 for one cycle, then moves to IDLE.
- Per-instruction period is ISSUE_GAP+1 cycles. An N-word run takes N*(ISSUE_GAP+1)+2 cycles from start to done.
- instr holds its value between issues; it is never driven to a bubble value. Consecutive identical words still each produce an instr_valid pulse.
- abort=1 in any non-IDLE state: the next state is IDLE, busy=0, no done, and no further res_valid. instr keeps its last value.
- start while busy is ignored.
- abort and start together in IDLE: abort wins, no run starts.
- pc never exceeds len-1; no wrap occurs within a run.

Test Plan:
- Load mem[0..2] = 14'h0E05, 14'h0F09, 14'h1476; prog_len=3; start -> instr_valid pulses 4 cycles apart with those words, in order; three res_valid pulses with res_idx 0,1,2, each ISSUE_GAP cycles after its issue; done one cycle after the third res_valid; busy low at done.
- Core model returns dataout=8'hA5, carry=1, sign=0, zero=0 at sample time -> res_data=8'hA5, res_flags=3'b100.
- prog_len=0, start -> done pulses the next cycle, no instr_valid, busy stays 0. prog_len=20 -> exactly 16 issues.
- load_en during a run with load_addr=1, load_data=14'h3FFF -> mem[1] is unchanged, verified by the next run's instr.
- abort asserted in WAIT of the second instruction -> no further res_valid, no done, IDLE next cycle. A new start then restarts at res_idx 0.
- rst_n pulled low mid-WAIT (asynchronous, between clock edges) -> all outputs 0 immediately. After release, a start replays the retained program correctly.
